// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
//   Shared definitions for the rx-side frame assembler.
//   - DEF_DATA_WIDTH / DEF_FRAME_WORDS : default word width and words per frame
//   - len_width()  : width of a frame length field able to hold 0..frame_words
//   - slot_lsb()   : bit offset of slot i inside a packed frame
// ---------------------------------------------------------------------------
package hs_pkg;

    localparam int DEF_DATA_WIDTH  = 5;
    localparam int DEF_FRAME_WORDS = 4;

    // A frame length runs 0..FRAME_WORDS inclusive, hence the +1.
    function automatic int len_width(input int frame_words);
        return $clog2(frame_words + 1);
    endfunction

    // Word i of a packed frame lives at [i*width +: width].
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/hs_frame_buf.sv
// ---------------------------------------------------------------------------
// hs_frame_buf
//   One half of the ping-pong frame store: a slot array, a length and a
//   full flag. The top decides which buffer is written/closed/released.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : write wr_data into slot wr_idx
//   wr_idx     : slot index
//   wr_data    : word to store
//   close      : mark buffer full with length close_len
//   close_len  : number of valid words in the closed frame
//   free       : frame consumed; buffer becomes empty
//   full       : buffer holds a closed frame
//   len        : valid words in the closed frame (0 when empty)
//   data       : packed frame, slots at or above len forced to zero
// ---------------------------------------------------------------------------
module hs_frame_buf
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int LEN_W       = len_width(DEF_FRAME_WORDS),
    parameter int IDX_W       = $clog2(DEF_FRAME_WORDS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              close,
    input  logic [LEN_W-1:0]                  close_len,
    input  logic                              free,
    output logic                              full,
    output logic [LEN_W-1:0]                  len,
    output logic [FRAME_WORDS*DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] slots [FRAME_WORDS];

    // NOTE: the slot array is deliberately not reset; len clears on reset and
    // every slot at or above len is masked, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slots[wr_idx] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            len  <= '0;
        end else if (close) begin
            full <= 1'b1;
            len  <= close_len;
        end else if (free) begin
            full <= 1'b0;
            len  <= '0;
        end
    end

    // Unused tail slots read as zero so a short frame is clean on the bus.
    for (genvar i = 0; i < FRAME_WORDS; i++) begin : g_slot
        assign data[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
            (LEN_W'(i) < len) ? slots[i] : '0;
    end

endmodule

// File: rtl/hs_rx_frame_assembler.sv
// ---------------------------------------------------------------------------
// hs_rx_frame_assembler
//   Packs FRAME_WORDS handshake words into one wide frame and offers it to
//   the switch core. Two buffers alternate: one fills while the other waits
//   for the core, so one word per cycle keeps flowing.
// Ports
//   clk, rst     : rx clock, asynchronous active-high reset
//   in_valid     : word valid
//   in_data      : word
//   in_ready     : word accepted when in_valid && in_ready
//   flush        : close the current partial frame
//   frame_valid  : frame available
//   frame_data   : packed frame, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   frame_len    : valid words in the frame (1..FRAME_WORDS)
//   frame_ready  : core takes the frame when frame_valid && frame_ready
//   stat_frames  : frames popped, wraps at 2^16
// ---------------------------------------------------------------------------
module hs_rx_frame_assembler
    import hs_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int FRAME_WORDS = DEF_FRAME_WORDS,
    localparam int LEN_W       = len_width(FRAME_WORDS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              in_ready,
    input  logic                              flush,
    output logic                              frame_valid,
    output logic [FRAME_WORDS*DATA_WIDTH-1:0] frame_data,
    output logic [LEN_W-1:0]                  frame_len,
    input  logic                              frame_ready,
    output logic [15:0]                       stat_frames
);

    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam int FD_W  = FRAME_WORDS * DATA_WIDTH;

    logic [IDX_W-1:0] cnt;
    logic             wr_sel;
    logic             rd_sel;

    logic [1:0]       full;
    logic [LEN_W-1:0] buf_len  [2];
    logic [FD_W-1:0]  buf_data [2];

    logic             accept;
    logic             last_word;
    logic             flush_close;
    logic             close;
    logic [LEN_W-1:0] close_len;
    logic             pop;

    // The write-side buffer is never full while it is filling, so the
    // handshake simply stalls once both buffers hold closed frames.
    assign in_ready    = !full[wr_sel] && !rst;
    assign accept      = in_valid && in_ready;
    assign last_word   = accept && (cnt == IDX_W'(FRAME_WORDS - 1));
    // A flush only closes a non-empty frame, counting a word accepted in the
    // same cycle; if that word completes the frame the full close covers it.
    assign flush_close = flush && !last_word && ((cnt != '0) || accept);
    assign close       = last_word || flush_close;
    assign close_len   = LEN_W'(cnt) + LEN_W'(accept);
    assign pop         = frame_valid && frame_ready;

    // Close targets wr_sel and pop targets rd_sel; they are always different
    // buffers when both fire, so both take effect in the same cycle.
    for (genvar b = 0; b < 2; b++) begin : g_buf
        hs_frame_buf #(
            .DATA_WIDTH  (DATA_WIDTH),
            .FRAME_WORDS (FRAME_WORDS),
            .LEN_W       (LEN_W),
            .IDX_W       (IDX_W)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (accept && (wr_sel == 1'(b))),
            .wr_idx    (cnt),
            .wr_data   (in_data),
            .close     (close && (wr_sel == 1'(b))),
            .close_len (close_len),
            .free      (pop && (rd_sel == 1'(b))),
            .full      (full[b]),
            .len       (buf_len[b]),
            .data      (buf_data[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            stat_frames <= '0;
        end else begin
            if (close) begin
                cnt    <= '0;
                wr_sel <= ~wr_sel;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            if (pop) begin
                rd_sel      <= ~rd_sel;
                stat_frames <= stat_frames + 16'd1;
            end
        end
    end

    assign frame_valid = full[rd_sel];
    assign frame_data  = buf_data[rd_sel];
    assign frame_len   = buf_len[rd_sel];

endmodule

// File: tb/tb_hs_rx_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_hs_rx_frame_assembler
//   Directed stimulus for hs_rx_frame_assembler (DATA_WIDTH=5, FRAME_WORDS=4).
//   A queue-based model of pending frames predicts every output each cycle;
//   literal expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_hs_rx_frame_assembler;

    localparam int DW    = 5;
    localparam int FW    = 4;
    localparam int FD    = DW * FW;
    localparam int LEN_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic              flush;
    logic              frame_valid;
    logic [FD-1:0]     frame_data;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_ready;
    logic [15:0]       stat_frames;

    int passed = 0;
    int total  = 0;

    // Model state: closed frames waiting for the core, plus the partial frame.
    logic [FD-1:0] m_data_q [$];
    int            m_len_q  [$];
    logic [FD-1:0] m_part;
    int            m_part_len;
    int            m_stat;

    hs_rx_frame_assembler #(
        .DATA_WIDTH  (DW),
        .FRAME_WORDS (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_len   (frame_len),
        .frame_ready (frame_ready),
        .stat_frames (stat_frames)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Apply one clock edge worth of behaviour to the model, using the inputs
    // as they stand just before the edge.
    task automatic model_edge();
        bit accept;
        bit pop;
        if (rst) begin
            m_data_q.delete();
            m_len_q.delete();
            m_part     = '0;
            m_part_len = 0;
            m_stat     = 0;
            return;
        end
        accept = in_valid && (m_len_q.size() < 2);
        pop    = (m_len_q.size() > 0) && frame_ready;
        if (pop) begin
            m_data_q.delete(0);
            m_len_q.delete(0);
            m_stat = (m_stat + 1) % 65536;
        end
        if (accept) begin
            m_part = m_part | (FD'(in_data) << (m_part_len * DW));
            m_part_len++;
        end
        if (m_part_len == FW || (flush && m_part_len > 0)) begin
            m_data_q.push_back(m_part);
            m_len_q.push_back(m_part_len);
            m_part     = '0;
            m_part_len = 0;
        end
    endtask

    task automatic compare_all();
        check("in_ready", 32'(in_ready), 32'(!rst && (m_len_q.size() < 2)));
        check("frame_valid", 32'(frame_valid), 32'(m_len_q.size() > 0));
        check("stat_frames", 32'(stat_frames), 32'(m_stat));
        if (m_len_q.size() > 0) begin
            check("frame_data", 32'(frame_data), 32'(m_data_q[0]));
            check("frame_len", 32'(frame_len), 32'(m_len_q[0]));
        end else if (rst) begin
            check("rst_frame_data", 32'(frame_data), 32'd0);
            check("rst_frame_len", 32'(frame_len), 32'd0);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Present one word and hold it until the handshake completes.
    task automatic send_word(input logic [DW-1:0] w);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = w;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = in_ready;
            tick();
            n++;
        end
        check("send_word_accepted", 32'(acc), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        flush       = 1'b0;
        frame_ready = 1'b0;
        m_part      = '0;
        m_part_len  = 0;
        m_stat      = 0;

        // 1: reset state and release
        tick();
        tick();
        check("t1_in_ready_rst", 32'(in_ready), 32'd0);
        check("t1_frame_valid_rst", 32'(frame_valid), 32'd0);
        check("t1_frame_len_rst", 32'(frame_len), 32'd0);
        check("t1_stat_rst", 32'(stat_frames), 32'd0);
        rst = 1'b0;
        #1;
        check("t1_in_ready_release", 32'(in_ready), 32'd1);

        // 2: four words back to back with the core ready
        frame_ready = 1'b1;
        for (int w = 1; w <= 4; w++) send_word(DW'(w));
        in_valid = 1'b0;
        check("t2_frame_valid", 32'(frame_valid), 32'd1);
        check("t2_frame_data", 32'(frame_data), 32'h20C41);
        check("t2_frame_len", 32'(frame_len), 32'd4);
        tick();
        check("t2_stat", 32'(stat_frames), 32'd1);
        check("t2_popped", 32'(frame_valid), 32'd0);

        // 3: backpressure with nine words
        frame_ready = 1'b0;
        for (int w = 1; w <= 8; w++) send_word(DW'(w));
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        check("t3_first_frame", 32'(frame_data), 32'h20C41);
        in_data = 5'd9;
        for (int i = 0; i < 3; i++) tick();
        check("t3_ninth_held", 32'(in_ready), 32'd0);
        frame_ready = 1'b1;
        tick();
        check("t3_second_frame", 32'(frame_data), 32'h41CC5);
        check("t3_ready_after_pop", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_drained", 32'(frame_valid), 32'd0);
        check("t3_stat", 32'(stat_frames), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_ninth_len", 32'(frame_len), 32'd1);
        check("t3_ninth_data", 32'(frame_data), 32'd9);
        tick();

        // 4: partial frame closed by flush, then an empty flush
        frame_ready = 1'b0;
        send_word(5'd7);
        send_word(5'd9);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_frame_len", 32'(frame_len), 32'd2);
        check("t4_frame_data", 32'(frame_data), 32'h00127);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        flush       = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("t4_empty_flush", 32'(frame_valid), 32'd0);

        // 5: flush alongside the third word, then alongside the fourth
        send_word(5'd1);
        send_word(5'd2);
        flush = 1'b1;
        send_word(5'd5);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_frame_len", 32'(frame_len), 32'd3);
        check("t5_frame_data", 32'(frame_data), 32'h01441);
        check("t5_slot3_zero", 32'(frame_data[19:15]), 32'd0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        for (int w = 1; w <= 3; w++) send_word(DW'(w));
        flush = 1'b1;
        send_word(5'd4);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_full_flush_len", 32'(frame_len), 32'd4);
        tick();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        tick();
        check("t5_no_extra_frame", 32'(frame_valid), 32'd0);

        // 6: reset in the middle of a frame
        frame_ready = 1'b1;
        send_word(5'd1);
        send_word(5'd2);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t6_no_frame", 32'(frame_valid), 32'd0);
        check("t6_stat_cleared", 32'(stat_frames), 32'd0);
        send_word(5'd4);
        send_word(5'd3);
        send_word(5'd2);
        send_word(5'd1);
        in_valid = 1'b0;
        check("t6_clean_data", 32'(frame_data), 32'h08864);
        check("t6_clean_len", 32'(frame_len), 32'd4);
        tick();
        check("t6_stat", 32'(stat_frames), 32'd1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
